mult_div_unit: RTL

//  Iterative multiply/divide unit for the execute stage: MULT, MULTU, DIV, DIVU.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/mult_div_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS execute-stage units.
package mips_pkg;

    localparam int MDU_DATA_WIDTH = 32;
    localparam int MDU_ITERS      = 32;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_t;

    typedef enum logic [1:0] {
        MDU_IDLE  = 2'b00,
        MDU_RUN   = 2'b01,
        MDU_FIXUP = 2'b10
    } mdu_state_t;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: MULT, MULTU, DIV, DIVU producing HI/LO.
// Works on operand magnitudes for one bit per cycle, then applies the sign
// correction in a final FIXUP cycle, so every op has the same latency.
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = MDU_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    input  logic                  flush,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result_HI,
    output logic [DATA_WIDTH-1:0] result_LO
);

    localparam int         W         = DATA_WIDTH;
    localparam logic [5:0] LAST_ITER = 6'(W - 1);

    mdu_state_t     state;
    mdu_state_t     state_next;

    mdu_op_t        op_q;
    logic           neg_a_q;
    logic           neg_b_q;
    logic           div_zero_q;
    logic [W-1:0]   step_operand_q;
    logic [2*W-1:0] acc_q;
    logic [5:0]     iter_q;

    // Decode of the incoming request, only consumed at the start edge.
    mdu_op_t        op_in;
    logic           signed_in;
    logic           is_div_in;
    logic           neg_a_in;
    logic           neg_b_in;
    logic [W-1:0]   mag_a_in;
    logic [W-1:0]   mag_b_in;

    assign op_in     = mdu_op_t'(op);
    assign signed_in = (op_in == MDU_MULT) || (op_in == MDU_DIV);
    assign is_div_in = (op_in == MDU_DIV) || (op_in == MDU_DIVU);
    assign neg_a_in  = signed_in && operand_a[W-1];
    assign neg_b_in  = signed_in && operand_b[W-1];
    assign mag_a_in  = neg_a_in ? (-operand_a) : operand_a;
    assign mag_b_in  = neg_b_in ? (-operand_b) : operand_b;

    logic is_div_q;
    assign is_div_q = (op_q == MDU_DIV) || (op_q == MDU_DIVU);

    // The upper accumulator half is the partial product / partial remainder;
    // the lower half starts as the multiplier / dividend and is shifted out
    // one bit per iteration while product / quotient bits shift in.
    logic [W:0]     add_sum;
    logic [W:0]     sub_diff;
    logic [2*W-1:0] acc_step;

    // One shift-add (multiply) or one restoring-divide step on the accumulator.
    always_comb begin
        add_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, step_operand_q};
        sub_diff = acc_q[2*W-1:W-1] - {1'b0, step_operand_q};
        acc_step = acc_q;
        if (is_div_q) begin
            if (!sub_diff[W]) begin
                acc_step = {sub_diff[W-1:0], acc_q[W-2:0], 1'b1};
            end else begin
                acc_step = {acc_q[2*W-2:0], 1'b0};
            end
        end else begin
            if (acc_q[0]) begin
                acc_step = {add_sum, acc_q[W-1:1]};
            end else begin
                acc_step = {1'b0, acc_q[2*W-1:1]};
            end
        end
    end

    // Sign correction of the magnitude result. Divide by zero naturally
    // leaves the dividend as remainder; the quotient is forced to all ones
    // so the signed case does not negate it.
    logic           neg_result;
    logic [2*W-1:0] product_fix;
    logic [W-1:0]   quot_fix;
    logic [W-1:0]   rem_fix;
    logic [W-1:0]   hi_next;
    logic [W-1:0]   lo_next;

    assign neg_result  = neg_a_q ^ neg_b_q;
    assign product_fix = neg_result ? (-acc_q) : acc_q;
    assign quot_fix    = div_zero_q ? '1
                       : (neg_result ? (-acc_q[W-1:0]) : acc_q[W-1:0]);
    assign rem_fix     = neg_a_q ? (-acc_q[2*W-1:W]) : acc_q[2*W-1:W];
    assign hi_next     = is_div_q ? rem_fix  : product_fix[2*W-1:W];
    assign lo_next     = is_div_q ? quot_fix : product_fix[W-1:0];

    assign busy = (state != MDU_IDLE);

    // State register for the IDLE -> RUN -> FIXUP sequence.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= MDU_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; flush squashes any in-flight op and blocks a new start.
    always_comb begin
        state_next = state;
        case (state)
            MDU_IDLE: begin
                if (start && !flush) begin
                    state_next = MDU_RUN;
                end
            end
            MDU_RUN: begin
                if (flush) begin
                    state_next = MDU_IDLE;
                end else if (iter_q == LAST_ITER) begin
                    state_next = MDU_FIXUP;
                end
            end
            MDU_FIXUP: begin
                state_next = MDU_IDLE;
            end
            default: begin
                state_next = MDU_IDLE;
            end
        endcase
    end

    // Datapath: latch operands at start, iterate in RUN, commit results in FIXUP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q           <= MDU_MULT;
            neg_a_q        <= 1'b0;
            neg_b_q        <= 1'b0;
            div_zero_q     <= 1'b0;
            step_operand_q <= '0;
            acc_q          <= '0;
            iter_q         <= '0;
            done           <= 1'b0;
            result_HI      <= '0;
            result_LO      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                MDU_IDLE: begin
                    if (start && !flush) begin
                        op_q           <= op_in;
                        neg_a_q        <= neg_a_in;
                        neg_b_q        <= neg_b_in;
                        div_zero_q     <= (operand_b == '0);
                        step_operand_q <= is_div_in ? mag_b_in : mag_a_in;
                        acc_q          <= {{W{1'b0}}, (is_div_in ? mag_a_in : mag_b_in)};
                        iter_q         <= '0;
                    end
                end
                MDU_RUN: begin
                    if (!flush) begin
                        acc_q  <= acc_step;
                        iter_q <= iter_q + 6'd1;
                    end
                end
                MDU_FIXUP: begin
                    if (!flush) begin
                        result_HI <= hi_next;
                        result_LO <= lo_next;
                        done      <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
